// File: rtl/sp_block_writer.sv
// sp_block_writer: drains one N x N sample block from the embedded S' RAM into external SRAM, one write per cycle
// Clock/Resetn: rising-edge clock, asynchronous active-low reset
// start/plane/blk_row/blk_col/clip_en: block request, latched when accepted in IDLE
// Address_Sp_a/Data_out_Sp_a: RAM port A read address and its 1-cycle-late read data
// SRAM_address/SRAM_write_data/SRAM_we_n: registered SRAM write port
// ready/done: idle indicator and one-cycle block-complete pulse
module sp_block_writer #(
    parameter int SAMPLE_W = 16,
    parameter int ADDR_W   = 18,
    parameter int RAM_AW   = 8,
    parameter int Y_BLK    = 16,
    parameter int C_BLK    = 8,
    parameter int Y_BASE   = 27648,
    parameter int U_BASE   = 55296,
    parameter int V_BASE   = 69120,
    parameter int Y_STRIDE = 320,
    parameter int C_STRIDE = 160
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic                  start,
    input  logic [1:0]            plane,
    input  logic [7:0]            blk_row,
    input  logic [7:0]            blk_col,
    input  logic                  clip_en,
    output logic [RAM_AW-1:0]     Address_Sp_a,
    input  logic [2*SAMPLE_W-1:0] Data_out_Sp_a,
    output logic [ADDR_W-1:0]     SRAM_address,
    output logic [SAMPLE_W-1:0]   SRAM_write_data,
    output logic                  SRAM_we_n,
    output logic                  ready,
    output logic                  done
);
    localparam int AW = ADDR_W + 8;
    typedef enum logic [2:0] {IDLE, LEADIN0, LEADIN1, WR_EVEN, WR_ODD, LAST_ODD, FINISH} state_t;
    state_t state;
    logic [1:0] pl;
    logic [7:0] rb, cb;
    logic clip;
    logic [4:0] r, c, n;
    logic [2*SAMPLE_W-1:0] word;
    logic [AW-1:0] base, stride, addr_full;
    logic [SAMPLE_W-1:0] sample;
    logic writing;
    function automatic logic [SAMPLE_W-1:0] clamp(input logic [SAMPLE_W-1:0] s, input logic en);
        return !en ? s : s[SAMPLE_W-1] ? '0 : (s > SAMPLE_W'(255)) ? SAMPLE_W'(255) : s;
    endfunction
    always_comb begin
        n = (pl == 2'd0) ? 5'(Y_BLK) : 5'(C_BLK);
        base = (pl == 2'd0) ? AW'(Y_BASE) : (pl == 2'd1) ? AW'(U_BASE) : AW'(V_BASE);
        stride = (pl == 2'd0) ? AW'(Y_STRIDE) : AW'(C_STRIDE);
        addr_full = base + (AW'(rb) * AW'(n) + AW'(r)) * stride + AW'(cb) * AW'(n) + AW'(c);
        sample = (state == WR_EVEN) ? word[2*SAMPLE_W-1:SAMPLE_W] : word[SAMPLE_W-1:0];
        writing = (state == WR_EVEN) || (state == WR_ODD) || (state == LAST_ODD);
    end
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= IDLE;
            pl <= '0;
            rb <= '0;
            cb <= '0;
            clip <= 1'b0;
            r <= '0;
            c <= '0;
            word <= '0;
            Address_Sp_a <= '0;
            SRAM_address <= '0;
            SRAM_write_data <= '0;
            SRAM_we_n <= 1'b1;
            ready <= 1'b1;
            done <= 1'b0;
        end else begin
            // 5-bit counters with explicit wrap so a 16-wide block never relies on 4-bit overflow
            if (writing) begin
                SRAM_we_n <= 1'b0;
                SRAM_address <= addr_full[ADDR_W-1:0];
                SRAM_write_data <= clamp(sample, clip);
                r <= (r == n - 5'd1) ? 5'd0 : r + 5'd1;
                c <= (r == n - 5'd1) ? c + 5'd1 : c;
            end
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        pl <= plane;
                        rb <= blk_row;
                        cb <= blk_col;
                        clip <= clip_en;
                        r <= '0;
                        c <= '0;
                        Address_Sp_a <= '0;
                        ready <= 1'b0;
                        state <= LEADIN0;
                    end
                end
                LEADIN0: begin
                    Address_Sp_a <= Address_Sp_a + RAM_AW'(1);
                    state <= LEADIN1;
                end
                LEADIN1: begin
                    word <= Data_out_Sp_a;
                    state <= WR_EVEN;
                end
                WR_EVEN: state <= (r == n - 5'd2 && c == n - 5'd1) ? LAST_ODD : WR_ODD;
                WR_ODD: begin
                    word <= Data_out_Sp_a;
                    Address_Sp_a <= Address_Sp_a + RAM_AW'(1);
                    state <= WR_EVEN;
                end
                LAST_ODD: state <= FINISH;
                FINISH: begin
                    SRAM_we_n <= 1'b1;
                    done <= 1'b1;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sp_block_writer.sv
// tb_sp_block_writer: randomized self-checking bench for sp_block_writer against a per-sample reference model
module tb_sp_block_writer;
    logic Clock = 1'b0;
    logic Resetn = 1'b0;
    logic start = 1'b0;
    logic clip_en = 1'b0;
    logic [1:0] plane = '0;
    logic [7:0] blk_row = '0;
    logic [7:0] blk_col = '0;
    logic [7:0] Address_Sp_a;
    logic [31:0] Data_out_Sp_a;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic SRAM_we_n, ready, done;
    logic [31:0] ram [0:255];
    int checks = 0;
    int failures = 0;
    int exp_addr[$];
    int exp_data[$];
    int obs_addr[0:255];
    int obs_data[0:255];

    sp_block_writer dut (
        .Clock(Clock), .Resetn(Resetn), .start(start), .plane(plane),
        .blk_row(blk_row), .blk_col(blk_col), .clip_en(clip_en),
        .Address_Sp_a(Address_Sp_a), .Data_out_Sp_a(Data_out_Sp_a),
        .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data),
        .SRAM_we_n(SRAM_we_n), .ready(ready), .done(done)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) Data_out_Sp_a <= ram[Address_Sp_a];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic build(input int p, input int rb, input int cb, input int cl);
        int n, base, stride, k, v;
        logic [31:0] w;
        logic [15:0] s;
        shortint sv;
        n = (p == 0) ? 16 : 8;
        base = (p == 0) ? 27648 : (p == 1) ? 55296 : 69120;
        stride = (p == 0) ? 320 : 160;
        exp_addr.delete();
        exp_data.delete();
        for (int c = 0; c < n; c++)
            for (int r = 0; r < n; r++) begin
                k = c * (n / 2) + r / 2;
                w = ram[k];
                s = (r % 2 == 0) ? w[31:16] : w[15:0];
                sv = s;
                v = cl ? ((sv < 0) ? 0 : (sv > 255) ? 255 : int'(sv)) : int'(s);
                exp_addr.push_back((base + (rb * n + r) * stride + cb * n + c) % (1 << 18));
                exp_data.push_back(v);
            end
    endtask

    task automatic run_block(input int p, input int rb, input int cb, input int cl, input string tag);
        int nn, wi;
        build(p, rb, cb, cl);
        nn = exp_addr.size();
        wi = 0;
        check({tag, "_ready_in"}, ready, 1);
        plane = 2'(p);
        blk_row = 8'(rb);
        blk_col = 8'(cb);
        clip_en = cl[0];
        start = 1'b1;
        @(posedge Clock);
        #1;
        start = 1'b0;
        plane = 2'($urandom);
        blk_row = 8'($urandom);
        blk_col = 8'($urandom);
        clip_en = 1'($urandom);
        for (int k = 0; k <= 3 + nn; k++) begin
            @(negedge Clock);
            if (!SRAM_we_n) begin
                if (wi < nn) begin
                    check({tag, "_addr"}, SRAM_address, exp_addr[wi]);
                    check({tag, "_data"}, SRAM_write_data, exp_data[wi]);
                    obs_addr[wi] = int'(SRAM_address);
                    obs_data[wi] = int'(SRAM_write_data);
                end
                wi++;
            end
            check({tag, "_we_n"}, SRAM_we_n, (k >= 3 && k <= 2 + nn) ? 0 : 1);
            check({tag, "_done"}, done, (k == 3 + nn) ? 1 : 0);
            if (k == 5) begin
                start = 1'b1;
                plane = 2'($urandom);
            end
            if (k == 6) start = 1'b0;
        end
        check({tag, "_count"}, wi, nn);
        check({tag, "_ready_out"}, ready, 1);
    endtask

    initial begin
        for (int k = 0; k < 256; k++) ram[k] = {16'(2 * k), 16'(2 * k + 1)};
        #23;
        check("rst_we_n", SRAM_we_n, 1);
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_addr", SRAM_address, 0);
        check("rst_data", SRAM_write_data, 0);
        check("rst_ram_addr", Address_Sp_a, 0);
        @(negedge Clock);
        Resetn = 1'b1;
        run_block(0, 0, 0, 0, "y00");
        check("y00_w0_addr", obs_addr[0], 27648);
        check("y00_w0_data", obs_data[0], 0);
        check("y00_w1_addr", obs_addr[1], 27968);
        check("y00_w1_data", obs_data[1], 1);
        check("y00_w16_addr", obs_addr[16], 27649);
        check("y00_w16_data", obs_data[16], 16);
        run_block(1, 2, 3, 0, "u23");
        check("u23_first", obs_addr[0], 57880);
        check("u23_last", obs_addr[63], 59007);
        ram[0] = {16'hFF80, 16'h012C};
        run_block(2, 1, 1, 1, "clip");
        check("clip_d0", obs_data[0], 0);
        check("clip_d1", obs_data[1], 255);
        run_block(2, 1, 1, 0, "noclip");
        check("noclip_d0", obs_data[0], 16'hFF80);
        check("noclip_d1", obs_data[1], 16'h012C);
        run_block(3, 4, 5, 0, "v_alias");
        run_block(2, 255, 255, 0, "wrap");
        for (int k = 0; k < 256; k++) ram[k] = $urandom;
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge Clock);
            run_block(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                      int'($urandom_range(0, 255)), int'($urandom_range(0, 1)), "rand");
        end
        plane = 2'd0;
        blk_row = 8'd0;
        blk_col = 8'd0;
        start = 1'b1;
        @(posedge Clock);
        #1;
        start = 1'b0;
        for (int k = 0; k <= 32; k++) @(negedge Clock);
        check("mid_we_active", SRAM_we_n, 0);
        #2;
        Resetn = 1'b0;
        #1;
        check("mid_rst_we_n", SRAM_we_n, 1);
        check("mid_rst_ready", ready, 1);
        check("mid_rst_done", done, 0);
        check("mid_rst_addr", SRAM_address, 0);
        @(negedge Clock);
        Resetn = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge Clock);
            check("post_rst_we_n", SRAM_we_n, 1);
            check("post_rst_done", done, 0);
        end
        run_block(0, 1, 2, 1, "after_rst");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
